uart_req_scheduler: RTL and testbench

- Sequences the APB-to-UART request path: pops packed requests from the request FIFO that the APB slave fills, serializes each one into a UART byte frame, and handles the read responses.
- Reads: collects response bytes from UART RX, assembles them into rres and raises en_rres back to the APB slave.
- Sits between the request FIFO, the UART TX/RX byte interfaces and the APB slave response inputs.
- Enforces one outstanding read at a time, with a per-byte response timeout.

---
 rtl/uart_apb_pkg.sv | 27 ++
 rtl/uart_frame_tx.sv | 63 ++++++
 rtl/uart_req_scheduler.sv | 130 +++++++++++++
 tb/tb_uart_req_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_apb_pkg.sv
// Shared definitions for the APB-to-UART request path: scheduler state
// encoding, frame header bytes and frame-length helper.
package uart_apb_pkg;

    localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
    localparam logic [2:0] ST_LOAD_ENC    = 3'd1;
    localparam logic [2:0] ST_SEND_ENC    = 3'd2;
    localparam logic [2:0] ST_WAIT_RX_ENC = 3'd3;
    localparam logic [2:0] ST_RESP_ENC    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_LOAD    = ST_LOAD_ENC,
        ST_SEND    = ST_SEND_ENC,
        ST_WAIT_RX = ST_WAIT_RX_ENC,
        ST_RESP    = ST_RESP_ENC
    } state_t;

    localparam logic [7:0] HDR_WR = 8'hA5;
    localparam logic [7:0] HDR_RD = 8'h5A;

    // Bytes on the wire: header, address, and the data word for writes only.
    function automatic int frame_len(input bit wr, input int width, input int addrbits);
        return wr ? (1 + addrbits / 8 + width / 8) : (1 + addrbits / 8);
    endfunction

endpackage

// File: rtl/uart_frame_tx.sv
// Byte serializer: latches one packed request and shifts it out MSB first as a
// UART frame (header, address, optional data) over a valid/ready handshake.
module uart_frame_tx
    import uart_apb_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int ADDRBITS = 16
) (
    input  logic                  apb_clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [WIDTH+ADDRBITS:0] req,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  done,
    output logic                  is_wr
);

    localparam int FRAME_BITS = 8 + ADDRBITS + WIDTH;
    localparam int N_WR       = frame_len(1'b1, WIDTH, ADDRBITS);
    localparam int N_RD       = frame_len(1'b0, WIDTH, ADDRBITS);
    localparam int CNT_W      = $clog2(N_WR);
    localparam logic [CNT_W-1:0] LAST_WR = CNT_W'(N_WR - 1);
    localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(N_RD - 1);

    logic [FRAME_BITS-1:0] frame_q;
    logic [CNT_W-1:0]      byte_cnt;
    logic                  wr_q;
    logic                  last_byte;

    assign last_byte = (byte_cnt == (wr_q ? LAST_WR : LAST_RD));
    assign done      = tx_valid & tx_ready & last_byte;
    assign is_wr     = wr_q;
    // Current byte always sits at the top of the shift register, so it holds
    // steady for as long as the receiver stalls.
    assign tx_data   = tx_valid ? frame_q[FRAME_BITS-1 -: 8] : 8'h00;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge apb_clk or negedge reset) begin
        if (!reset) begin
            frame_q  <= '0;
            byte_cnt <= '0;
            wr_q     <= 1'b0;
            tx_valid <= 1'b0;
        end else if (load) begin
            frame_q  <= {(req[WIDTH+ADDRBITS] ? HDR_WR : HDR_RD), req[WIDTH+ADDRBITS-1:0]};
            wr_q     <= req[WIDTH+ADDRBITS];
            byte_cnt <= '0;
            tx_valid <= 1'b1;
        end else if (tx_valid && tx_ready) begin
            frame_q <= frame_q << 8;
            if (last_byte) begin
                tx_valid <= 1'b0;
                byte_cnt <= '0;
            end else begin
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_req_scheduler.sv
// Request scheduler: pops APB requests from the FIFO, frames them onto UART TX,
// and for reads assembles the RX reply (or a timeout error) into rres.
module uart_req_scheduler
    import uart_apb_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               ADDRBITS = 16,
    parameter int               TIMEOUT  = 4096,
    parameter logic [WIDTH-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                    apb_clk,
    input  logic                    reset,
    input  logic                    fifo_empty,
    input  logic [WIDTH+ADDRBITS:0] fifo_rdata,
    output logic                    fifo_ren,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic [WIDTH-1:0]        rres,
    output logic                    en_rres,
    input  logic                    rres_ack,
    output logic                    resp_err,
    output logic                    busy
);

    localparam int RX_BYTES = WIDTH / 8;
    localparam int RX_CNT_W = $clog2(RX_BYTES + 1);
    localparam int TMO_W    = $clog2(TIMEOUT);
    localparam logic [RX_CNT_W-1:0] RX_LAST  = RX_CNT_W'(RX_BYTES - 1);
    localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t              state, state_nxt;
    logic [RX_CNT_W-1:0] rx_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [WIDTH-1:0]    rres_shift;
    logic [WIDTH-1:0]    rx_word;
    logic                tx_done;
    logic                tx_is_wr;
    logic                rx_done;
    logic                tmo_hit;

    uart_frame_tx #(
        .WIDTH    (WIDTH),
        .ADDRBITS (ADDRBITS)
    ) u_frame_tx (
        .apb_clk  (apb_clk),
        .reset    (reset),
        .load     (state == ST_LOAD),
        .req      (fifo_rdata),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .done     (tx_done),
        .is_wr    (tx_is_wr)
    );

    assign rx_word = (rres_shift << 8) | WIDTH'(rx_data);
    assign rx_done = (state == ST_WAIT_RX) && rx_valid && (rx_cnt == RX_LAST);
    // A byte arriving in the same cycle always wins over the timeout.
    assign tmo_hit = (state == ST_WAIT_RX) && !rx_valid && (tmo_cnt == TMO_LAST);
    assign busy    = (state != ST_IDLE);

    always_ff @(posedge apb_clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        fifo_ren  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_ren  = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD:    state_nxt = ST_SEND;
            ST_SEND:    if (tx_done) state_nxt = tx_is_wr ? ST_IDLE : ST_WAIT_RX;
            ST_WAIT_RX: if (rx_done || tmo_hit) state_nxt = ST_RESP;
            ST_RESP:    if (rres_ack) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge apb_clk or negedge reset) begin
        if (!reset) begin
            rx_cnt     <= '0;
            tmo_cnt    <= '0;
            rres_shift <= '0;
            rres       <= '0;
            en_rres    <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            unique case (state)
                ST_SEND: begin
                    if (tx_done && !tx_is_wr) begin
                        rx_cnt  <= '0;
                        tmo_cnt <= '0;
                    end
                end
                ST_WAIT_RX: begin
                    if (rx_valid) begin
                        rres_shift <= rx_word;
                        rx_cnt     <= rx_cnt + 1'b1;
                        tmo_cnt    <= '0;
                        if (rx_done) begin
                            rres     <= rx_word;
                            resp_err <= 1'b0;
                            en_rres  <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        rres     <= ERR_DATA;
                        resp_err <= 1'b1;
                        en_rres  <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_RESP: if (rres_ack) en_rres <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_req_scheduler.sv
// Scoreboard bench for uart_req_scheduler: directed requests push expected TX
// bytes and responses into queues; a negedge monitor pops and compares them.
module tb_uart_req_scheduler;

    localparam int WIDTH    = 32;
    localparam int ADDRBITS = 16;
    localparam int TIMEOUT  = 16;
    localparam int REQ_W    = WIDTH + ADDRBITS + 1;

    logic             apb_clk = 1'b0;
    logic             reset = 1'b0;
    logic             fifo_empty;
    logic [REQ_W-1:0] fifo_rdata = '0;
    logic             fifo_ren;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready = 1'b1;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_valid = 1'b0;
    logic [WIDTH-1:0] rres;
    logic             en_rres;
    logic             rres_ack = 1'b0;
    logic             resp_err;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;
    int ren_cnt  = 0;

    logic [7:0]  tx_exp[$];
    logic [32:0] rsp_exp[$];

    logic [REQ_W-1:0] fifo_mem[16];
    int wr_ptr = 0;
    int rd_ptr = 0;

    always #5 apb_clk = ~apb_clk;

    uart_req_scheduler #(
        .WIDTH    (WIDTH),
        .ADDRBITS (ADDRBITS),
        .TIMEOUT  (TIMEOUT),
        .ERR_DATA (32'hDEAD_BEEF)
    ) dut (
        .apb_clk    (apb_clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_ren   (fifo_ren),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rres       (rres),
        .en_rres    (en_rres),
        .rres_ack   (rres_ack),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    // Request FIFO model: read data appears one cycle after the pop strobe.
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge apb_clk) begin
        if (fifo_ren && (wr_ptr != rd_ptr)) begin
            fifo_rdata <= fifo_mem[rd_ptr % 16];
            rd_ptr     <= rd_ptr + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard pops plus handshake-protocol checks.
    logic       prev_ren   = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_en    = 1'b0;

    always @(negedge apb_clk) begin
        if (!reset) begin
            prev_ren   = 1'b0;
            prev_stall = 1'b0;
            prev_en    = 1'b0;
        end else begin
            if (fifo_ren) begin
                ren_cnt++;
                check("fifo_ren_nonempty", fifo_empty, 0);
                check("fifo_ren_one_cycle", prev_ren, 0);
            end
            if (prev_stall) begin
                check("tx_stall_valid", tx_valid, 1);
                check("tx_stall_data", tx_data, prev_data);
            end
            if (tx_valid && tx_ready) begin
                if (tx_exp.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got byte %0h expected none at %0t", tx_data, $time);
                end else begin
                    check("tx_byte", tx_data, tx_exp.pop_front());
                end
            end
            if (en_rres && !prev_en) begin
                if (rsp_exp.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got %0h err %0b expected none", rres, resp_err);
                end else begin
                    check("rsp_word", {resp_err, rres}, rsp_exp.pop_front());
                end
            end
            prev_ren   = fifo_ren;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_en    = en_rres;
        end
    end

    task automatic push_req(input logic [REQ_W-1:0] r);
        fifo_mem[wr_ptr % 16] = r;
        wr_ptr++;
    endtask

    task automatic exp_bytes(input logic [7:0] b[]);
        foreach (b[i]) tx_exp.push_back(b[i]);
    endtask

    task automatic tick();
        @(posedge apb_clk);
        #1;
    endtask

    task automatic wait_busy(input logic lvl, input string name);
        int n = 0;
        while (busy !== lvl && n < 300) begin tick(); n++; end
        check(name, busy, lvl);
    endtask

    task automatic wait_tx_left(input int left, input string name);
        int n = 0;
        while (tx_exp.size() != left && n < 300) begin tick(); n++; end
        check(name, tx_exp.size(), left);
    endtask

    task automatic wait_en(input string name);
        int n = 0;
        while (!en_rres && n < 300) begin tick(); n++; end
        check(name, en_rres, 1);
    endtask

    task automatic rx_byte(input logic [7:0] b, input int gap);
        repeat (gap) tick();
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic ack();
        rres_ack = 1'b1;
        tick();
        rres_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int cyc;

        // Reset state
        repeat (2) @(posedge apb_clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_fifo_ren", fifo_ren, 0);
        check("rst_en_rres", en_rres, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_rres", rres, 0);
        reset = 1'b1;
        tick();

        // Posted write, no backpressure
        exp_bytes('{8'hA5, 8'h00, 8'h10, 8'h12, 8'h34, 8'h56, 8'h78});
        push_req({1'b1, 16'h0010, 32'h1234_5678});
        wait_busy(1, "wr_busy_rise");
        wait_busy(0, "wr_busy_fall");
        check("wr_tx_all_sent", tx_exp.size(), 0);
        check("wr_no_rres", en_rres, 0);
        check("wr_one_pop", ren_cnt, 1);

        // Read with gapped RX reply
        exp_bytes('{8'h5A, 8'h00, 8'h20});
        rsp_exp.push_back({1'b0, 32'hCAFE_BABE});
        push_req({1'b0, 16'h0020, 32'h0});
        wait_busy(1, "rd_busy_rise");
        wait_tx_left(0, "rd_tx_sent");
        rx_byte(8'hCA, 3);
        rx_byte(8'hFE, 7);
        rx_byte(8'hBA, 1);
        check("rd_no_early_rres", en_rres, 0);
        rx_byte(8'hBE, 12);
        check("rd_rres_latency", en_rres, 1);
        repeat (5) begin
            tick();
            check("rd_en_held", en_rres, 1);
            check("rd_rres_stable", rres, 32'hCAFE_BABE);
        end
        ack();
        check("rd_en_cleared", en_rres, 0);
        check("rd_idle_after_ack", busy, 0);

        // Write under alternating backpressure
        exp_bytes('{8'hA5, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04});
        push_req({1'b1, 16'hBEEF, 32'h0102_0304});
        cyc = 0;
        while (tx_exp.size() != 0 && cyc < 300) begin
            tx_ready = ~tx_ready;
            tick();
            cyc++;
        end
        check("bp_tx_all_sent", tx_exp.size(), 0);
        tx_ready = 1'b1;
        wait_busy(0, "bp_idle");

        // Timeout after two bytes; a late third byte is dropped
        exp_bytes('{8'h5A, 8'h00, 8'h30});
        rsp_exp.push_back({1'b1, 32'hDEAD_BEEF});
        push_req({1'b0, 16'h0030, 32'h0});
        wait_busy(1, "tmo_busy_rise");
        wait_tx_left(0, "tmo_tx_sent");
        rx_byte(8'hAB, 2);
        rx_byte(8'hCD, 2);
        cyc = 0;
        while (!en_rres && cyc < 100) begin tick(); cyc++; end
        check("tmo_latency", cyc, TIMEOUT);
        rx_byte(8'hEF, 1);
        check("tmo_late_rres", rres, 32'hDEAD_BEEF);
        check("tmo_late_err", resp_err, 1);
        check("tmo_late_en", en_rres, 1);
        ack();
        check("tmo_en_cleared", en_rres, 0);
        rx_byte(8'h77, 1);
        check("idle_rx_ignored", busy, 0);

        // Ordering: queued write waits for the read response to be acked
        base = ren_cnt;
        exp_bytes('{8'h5A, 8'h00, 8'h40});
        exp_bytes('{8'hA5, 8'h00, 8'h50, 8'hA1, 8'hB2, 8'hC3, 8'hD4});
        rsp_exp.push_back({1'b0, 32'h1122_3344});
        push_req({1'b0, 16'h0040, 32'h0});
        push_req({1'b1, 16'h0050, 32'hA1B2_C3D4});
        wait_tx_left(7, "ord_rd_sent");
        rx_byte(8'h11, 1);
        rx_byte(8'h22, 1);
        rx_byte(8'h33, 1);
        rx_byte(8'h44, 1);
        wait_en("ord_en");
        repeat (20) tick();
        check("ord_no_second_pop", ren_cnt, base + 1);
        check("ord_wr_not_started", tx_exp.size(), 7);
        check("ord_tx_quiet", tx_valid, 0);
        ack();
        wait_tx_left(0, "ord_wr_sent");
        wait_busy(0, "ord_idle");
        check("ord_two_pops", ren_cnt, base + 2);

        // Reset in the middle of a write frame
        exp_bytes('{8'hA5, 8'h00, 8'h60, 8'h55, 8'h66, 8'h77, 8'h88});
        push_req({1'b1, 16'h0060, 32'h5566_7788});
        wait_tx_left(4, "mid_three_sent");
        reset = 1'b0;
        #1;
        check("mid_rst_tx_valid", tx_valid, 0);
        check("mid_rst_busy", busy, 0);
        tx_exp.delete();
        repeat (2) @(posedge apb_clk);
        #1;
        reset = 1'b1;
        tick();
        exp_bytes('{8'hA5, 8'h00, 8'h70, 8'h99, 8'hAA, 8'hBB, 8'hCC});
        push_req({1'b1, 16'h0070, 32'h99AA_BBCC});
        wait_busy(1, "post_rst_busy_rise");
        wait_busy(0, "post_rst_idle");
        check("post_rst_tx_all_sent", tx_exp.size(), 0);

        repeat (3) tick();
        check("final_rsp_drained", rsp_exp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
